// File: rtl/bin_to_bcd_disp_if.sv
// Handshake and display bundle between a binary source and the BCD display converter.
// The master issues conversion requests; the slave returns status and display codes.
interface bin_to_bcd_disp_if #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic                  ovf;
    logic [4*DIGITS-1:0]   codes;

    modport master (
        output start, bin,
        input  busy, done, ovf, codes
    );

    modport slave (
        input  start, bin,
        output busy, done, ovf, codes
    );
endinterface

// File: rtl/bin_to_bcd_disp.sv
// Sequential double-dabble converter producing per-digit seven-segment decoder codes
// (0-9 digit, 4'hA off, 4'hB dash) with leading-zero blanking and overflow dashes.
module bin_to_bcd_disp #(
    parameter int BIN_W    = 14,
    parameter int DIGITS   = 4,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    bin_to_bcd_disp_if.slave   bus
);
    localparam int           BCD_W   = 4 * DIGITS;
    localparam int           CNT_W   = $clog2(BIN_W + 1);
    localparam logic [63:0]  MAX_VAL = 64'(10**DIGITS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FMT} state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   sh_q, sh_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic               ovf_q, ovf_d;
    logic [BCD_W-1:0]   codes_q, codes_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [BCD_W-1:0]   adj_bcd;
    logic [BCD_W-1:0]   fmt_codes;
    logic               seen_nz;

    // Add-3 correction is per nibble; no carry propagates between digits.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        assign adj_bcd[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                               : bcd_q[4*gi +: 4];
    end

    // Blank zeros above the most significant nonzero digit; digit 0 always shows.
    always_comb begin
        seen_nz   = 1'b0;
        fmt_codes = bcd_q;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (bcd_q[4*k +: 4] != 4'd0 || k == 0) begin
                seen_nz = 1'b1;
            end
            if (BLANK_LZ && !seen_nz) begin
                fmt_codes[4*k +: 4] = 4'hA;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        ovf_d      = ovf_q;
        codes_d    = codes_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sh_d       = bus.bin;
                    bcd_d      = '0;
                    cnt_d      = CNT_W'(BIN_W);
                    ovf_pend_d = (64'(bus.bin) > MAX_VAL);
                    busy_d     = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = {adj_bcd[BCD_W-2:0], sh_q[BIN_W-1]};
                sh_d  = sh_q << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FMT;
                end
            end
            FMT: begin
                codes_d = ovf_pend_q ? {DIGITS{4'hB}} : fmt_codes;
                ovf_d   = ovf_pend_q;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sh_q       <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
            codes_q    <= {DIGITS{4'hA}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            ovf_q      <= ovf_d;
            codes_q    <= codes_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.ovf   = ovf_q;
    assign bus.codes = codes_q;
endmodule
